memory_stage: RTL and testbench

//  Pipeline stage downstream of the execute stage: consumes Uop::execute_t over pipeline_if valid/stall,

---
 rtl/memory_stage.sv | 198 +++++++++++++++++++
 tb/tb_memory_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory pipeline stage: takes execute results, performs data-memory loads/stores,
// and hands results to writeback through a one-entry skid buffer and an ACTIVE slot.
module memory_stage #(
    parameter int XLEN = 32,
    parameter int ADDR_W = 32,
    parameter int EX_W = 4,
    parameter int RD_W = 5,
    parameter logic [EX_W-1:0] EX_MISALIGNED = EX_W'(4),
    localparam int EXEC_W = EX_W + RD_W + 2 * XLEN + 5,
    localparam int MEM_W = EX_W + RD_W + XLEN,
    localparam int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              u_valid,
    output logic              u_stall,
    input  logic [EXEC_W-1:0] uop_in,
    output logic              d_valid,
    input  logic              d_stall,
    output logic [MEM_W-1:0]  uop_out,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [STRB_W-1:0] dmem_wstrb,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic [1:0]        dbgState
);
    // Handshakes: upstream uop transfers on a rising edge where u_valid=1 and u_stall=0;
    // downstream result transfers where d_valid=1 and d_stall=0; a memory request
    // transfers where dmem_req_valid=1 and dmem_req_ready=1, with its fields held until then.

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2, DONE = 2'd3} state_t;

    state_t state, stateNext;

    logic              skidValid;
    logic [EXEC_W-1:0] skidUop;

    logic [EX_W-1:0]   activeEx;
    logic [RD_W-1:0]   activeRd;
    logic [XLEN-1:0]   activeAddrVal;
    logic [XLEN-1:0]   activeRs2;
    logic              activeStore;
    logic [1:0]        activeSize;
    logic              activeUns;
    logic [XLEN-1:0]   activeResult;

    // Candidate for the ACTIVE slot: a waiting skid entry always goes first.
    logic [EXEC_W-1:0] fillUop;
    logic [EX_W-1:0]   fEx;
    logic [RD_W-1:0]   fRd;
    logic [XLEN-1:0]   fRdVal;
    logic [XLEN-1:0]   fRs2;
    logic              fEn;
    logic              fStore;
    logic [1:0]        fSize;
    logic              fUns;
    logic              fMis;
    logic              fAccess;
    logic [EX_W-1:0]   fExOut;
    logic [XLEN-1:0]   fResult;

    assign fillUop = skidValid ? skidUop : uop_in;
    assign {fEx, fRd, fRdVal, fRs2, fEn, fStore, fSize, fUns} = fillUop;
    assign fMis    = (fSize == 2'd1 && fRdVal[0]) || (fSize[1] && fRdVal[1:0] != 2'd0);
    assign fAccess = fEn && (fEx == '0) && !fMis;
    assign fExOut  = (fEn && (fEx == '0) && fMis) ? EX_MISALIGNED : fEx;
    assign fResult = (fAccess && fStore) ? fRs2 : fRdVal;

    function automatic logic [XLEN-1:0] extractLoad(input logic [XLEN-1:0] rdata,
                                                    input logic [1:0] b,
                                                    input logic [1:0] size,
                                                    input logic uns);
        logic [7:0]  bv;
        logic [15:0] hv;
        bv = rdata[{b, 3'b000} +: 8];
        hv = rdata[{b[1], 4'b0000} +: 16];
        case (size)
            2'd0:    return uns ? XLEN'(bv) : {{(XLEN-8){bv[7]}}, bv};
            2'd1:    return uns ? XLEN'(hv) : {{(XLEN-16){hv[15]}}, hv};
            default: return rdata;
        endcase
    endfunction

    logic            complete;
    logic            captureLoad;
    logic            activeFree;
    logic            accept;
    logic            refill;
    logic            toSkid;
    logic [XLEN-1:0] loadVal;
    logic [XLEN-1:0] resultVal;

    always_comb begin
        stateNext      = state;
        complete       = 1'b0;
        captureLoad    = 1'b0;
        dmem_req_valid = 1'b0;
        loadVal        = extractLoad(dmem_rdata, activeAddrVal[1:0], activeSize, activeUns);
        case (state)
            REQ: begin
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    if (!activeStore)  stateNext = RSP;
                    else if (!d_stall) complete  = 1'b1;
                    else               stateNext = DONE;
                end
            end
            RSP: begin
                if (dmem_rsp_valid) begin
                    captureLoad = 1'b1;
                    if (!d_stall) complete  = 1'b1;
                    else          stateNext = DONE;
                end
            end
            DONE:    complete = !d_stall;
            default: ;
        endcase
        resultVal = (state == RSP) ? loadVal : activeResult;
        if (complete) stateNext = IDLE;
        activeFree = (state == IDLE) || complete;
        accept     = u_valid && !skidValid;
        refill     = activeFree && (skidValid || accept);
        toSkid     = accept && !activeFree;
        if (refill) stateNext = fAccess ? REQ : DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            skidValid     <= 1'b0;
            skidUop       <= '0;
            activeEx      <= '0;
            activeRd      <= '0;
            activeAddrVal <= '0;
            activeRs2     <= '0;
            activeStore   <= 1'b0;
            activeSize    <= 2'd0;
            activeUns     <= 1'b0;
            activeResult  <= '0;
            d_valid       <= 1'b0;
            uop_out       <= '0;
        end else begin
            state <= stateNext;
            if (refill) begin
                activeEx      <= fExOut;
                activeRd      <= fRd;
                activeAddrVal <= fRdVal;
                activeRs2     <= fRs2;
                activeStore   <= fStore;
                activeSize    <= fSize;
                activeUns     <= fUns;
                activeResult  <= fResult;
            end else if (captureLoad) begin
                activeResult  <= loadVal;
            end
            if (toSkid) begin
                skidValid <= 1'b1;
                skidUop   <= uop_in;
            end else if (refill && skidValid) begin
                skidValid <= 1'b0;
            end
            if (complete) begin
                d_valid <= 1'b1;
                uop_out <= {activeEx, activeRd, resultVal};
            end else if (!d_stall) begin
                d_valid <= 1'b0;
            end
        end
    end

    assign u_stall   = skidValid;
    assign dbgState  = state;
    assign dmem_addr = {activeAddrVal[ADDR_W-1:2], 2'b00};
    assign dmem_we   = activeStore;

    // Store data is replicated across lanes so the byte enables alone pick the bytes.
    always_comb begin
        dmem_wdata = activeRs2;
        dmem_wstrb = '0;
        case (activeSize)
            2'd0: begin
                dmem_wdata = {STRB_W{activeRs2[7:0]}};
                dmem_wstrb = STRB_W'(1) << activeAddrVal[1:0];
            end
            2'd1: begin
                dmem_wdata = {(XLEN/16){activeRs2[15:0]}};
                dmem_wstrb = STRB_W'(3) << activeAddrVal[1:0];
            end
            default: dmem_wstrb = '1;
        endcase
        if (!activeStore) dmem_wstrb = '0;
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed and random checks of memory_stage against a small reference model.
module tb_memory_stage;
  localparam int XLEN = 32;
  localparam int ADDR_W = 32;
  localparam int EXEC_W = 4 + 5 + 2 * XLEN + 5;
  localparam int MEM_W = 4 + 5 + XLEN;
  localparam int REQ_W = 1 + ADDR_W + XLEN + XLEN / 8;
  localparam logic [3:0] EX_MIS = 4'd4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              u_valid;
  logic              u_stall;
  logic [EXEC_W-1:0] uop_in;
  logic              d_valid;
  logic              d_stall;
  logic [MEM_W-1:0]  uop_out;
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_wdata;
  logic [3:0]        dmem_wstrb;
  logic              dmem_rsp_valid;
  logic [XLEN-1:0]   dmem_rdata;
  logic [1:0]        dbgState;

  memory_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W), .EX_MISALIGNED(EX_MIS)) dut (
    .clk(clk), .rst_n(rst_n), .u_valid(u_valid), .u_stall(u_stall), .uop_in(uop_in),
    .d_valid(d_valid), .d_stall(d_stall), .uop_out(uop_out),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr),
    .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata), .dbgState(dbgState)
  );

  // scoreboard
  logic [MEM_W-1:0] exp_q[$];
  logic [REQ_W-1:0] req_q[$];
  int checkCount = 0;
  int passCount = 0;
  int failCount = 0;
  int outCount = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
  endfunction

  // responder / stall controls
  bit randomMem = 0;
  bit useFixed = 0;
  bit randStall = 0;
  bit stallDir = 0;
  int readyDelay = 0;
  int rspDelay = 1;
  logic [31:0] fixedRdata = 32'h0;

  initial begin
    d_stall = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      d_stall = randStall ? ($urandom_range(0, 3) == 0) : stallDir;
    end
  end

  // memory responder: checks each request cycle against the model, then answers
  initial begin
    logic [REQ_W-1:0] curReq;
    bit reqActive;
    bit rspPend;
    int waitCnt;
    int rspCnt;
    logic [31:0] rspData;
    reqActive = 0; rspPend = 0; waitCnt = 0; rspCnt = 0; curReq = '0; rspData = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_rsp_valid = 1'b0;
      if (rspPend) begin
        if (rspCnt <= 1) begin
          dmem_rsp_valid = 1'b1;
          dmem_rdata = rspData;
          rspPend = 0;
        end else rspCnt--;
      end
      dmem_req_ready = 1'b0;
      if (!rst_n) reqActive = 0;
      else if (dmem_req_valid) begin
        if (!reqActive) begin
          check("req_expected", req_q.size() != 0, 1);
          curReq = (req_q.size() != 0) ? req_q.pop_front() : '0;
          reqActive = 1;
          waitCnt = randomMem ? $urandom_range(0, 3) : readyDelay;
        end
        check("req_fields", {dmem_we, dmem_addr, (dmem_we ? dmem_wdata : 32'h0), dmem_wstrb}, curReq);
        if (waitCnt == 0) begin
          dmem_req_ready = 1'b1;
          reqActive = 0;
          if (!dmem_we) begin
            rspPend = 1;
            rspCnt = randomMem ? $urandom_range(1, 4) : rspDelay;
            rspData = useFixed ? fixedRdata : memWord(dmem_addr);
          end
        end else waitCnt--;
      end
    end
  end

  // output monitor: one transfer per cycle with d_valid=1 and d_stall=0
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && d_valid && !d_stall) begin
        check("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("out_value", uop_out, exp_q.pop_front());
        outCount++;
      end
    end
  end

  // driver: model the uop, push expectations, then hold it until accepted
  task automatic sendUop(input logic [3:0] ex, input logic [4:0] rd, input logic [31:0] rv,
                         input logic [31:0] rs2, input logic en, input logic st,
                         input logic [1:0] size, input logic uns);
    logic mis, access;
    logic [1:0] b;
    logic [31:0] aligned, rdata, val, wd;
    logic [3:0] strb;
    logic [7:0] bv;
    logic [15:0] hv;
    int budget;
    b = rv[1:0];
    aligned = {rv[31:2], 2'b00};
    mis = (size == 2'd1 && rv[0]) || (size >= 2'd2 && b != 2'd0);
    access = en && ex == 4'd0 && !mis;
    if (!access) exp_q.push_back({(en && ex == 4'd0) ? EX_MIS : ex, rd, rv});
    else if (st) begin
      case (size)
        2'd0: begin strb = 4'b0001 << b; wd = {4{rs2[7:0]}}; end
        2'd1: begin strb = 4'b0011 << b; wd = {2{rs2[15:0]}}; end
        default: begin strb = 4'hF; wd = rs2; end
      endcase
      req_q.push_back({1'b1, aligned, wd, strb});
      exp_q.push_back({ex, rd, rs2});
    end else begin
      rdata = useFixed ? fixedRdata : memWord(aligned);
      bv = 8'(rdata >> (8 * b));
      hv = b[1] ? rdata[31:16] : rdata[15:0];
      case (size)
        2'd0: val = uns ? {24'h0, bv} : {{24{bv[7]}}, bv};
        2'd1: val = uns ? {16'h0, hv} : {{16{hv[15]}}, hv};
        default: val = rdata;
      endcase
      req_q.push_back({1'b0, aligned, 32'h0, 4'h0});
      exp_q.push_back({ex, rd, val});
    end
    u_valid = 1'b1;
    uop_in = {ex, rd, rv, rs2, en, st, size, uns};
    budget = 0;
    while (u_stall && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("accept_u_stall", u_stall, 0);
    @(negedge clk);
    u_valid = 1'b0;
  endtask

  task automatic waitOut(input int target);
    int n;
    n = 0;
    while (outCount < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("wait_out", outCount >= target, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    u_valid = 1'b0;
    uop_in = '0;
    repeat (3) @(negedge clk);
    check("rst_d_valid", d_valid, 0);
    check("rst_u_stall", u_stall, 0);
    check("rst_uop_out", uop_out, 0);
    check("rst_req_valid", dmem_req_valid, 0);
    check("rst_state", dbgState, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // reset while a load waits for its response; the late response must be ignored
    useFixed = 1; fixedRdata = 32'h1111_2222; rspDelay = 8;
    sendUop(4'd0, 5'd3, 32'h200, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    repeat (3) @(negedge clk);
    check("t1_in_rsp", dbgState, 2);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t1_rst_d_valid", d_valid, 0);
    check("t1_rst_req", dmem_req_valid, 0);
    check("t1_rst_state", dbgState, 0);
    rst_n = 1'b1;
    base = outCount;
    sendUop(4'd0, 5'd5, 32'h1234, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    check("t1_d_valid", d_valid, 1);
    check("t1_uop_out", uop_out, {4'd0, 5'd5, 32'h1234});
    repeat (6) @(negedge clk);
    check("t1_idle_state", dbgState, 0);
    check("t1_idle_d_valid", d_valid, 0);
    check("t1_out_count", outCount - base, 1);

    // signed byte load with slow response; skid fills behind it
    fixedRdata = 32'h80FF_FF7F; rspDelay = 3; readyDelay = 0;
    base = outCount;
    sendUop(4'd0, 5'd7, 32'h103, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    sendUop(4'd0, 5'd8, 32'hAAAA, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    check("t2_u_stall", u_stall, 1);
    sendUop(4'd0, 5'd9, 32'hBBBB, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    waitOut(base + 3);
    check("t2_u_stall_drained", u_stall, 0);

    // half store with ready delayed: request must hold steady
    readyDelay = 2;
    base = outCount;
    sendUop(4'd0, 5'd10, 32'h102, 32'hDEAD_BEEF, 1'b1, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("t3_req_valid", dmem_req_valid, 1);
      check("t3_req", {dmem_we, dmem_addr, dmem_wdata, dmem_wstrb},
            {1'b1, 32'h100, 32'hBEEF_BEEF, 4'b1100});
      @(negedge clk);
    end
    waitOut(base + 1);

    // misaligned word load, then unsigned half load
    readyDelay = 0; rspDelay = 1; fixedRdata = 32'h8001_0000;
    base = outCount;
    sendUop(4'd0, 5'd11, 32'h101, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
    check("t4_no_req", dmem_req_valid, 0);
    sendUop(4'd0, 5'd12, 32'h102, 32'h0, 1'b1, 1'b0, 2'd1, 1'b1);
    waitOut(base + 2);

    // downstream stall: outputs frozen, skid fills, order kept
    base = outCount;
    sendUop(4'd0, 5'd13, 32'h5001, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    sendUop(4'd0, 5'd14, 32'h5002, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    stallDir = 1;
    sendUop(4'd0, 5'd15, 32'h5003, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    check("t5_u_stall", u_stall, 1);
    repeat (2) @(negedge clk);
    check("t5_frozen_valid", d_valid, 1);
    check("t5_frozen_out", uop_out, {4'd0, 5'd13, 32'h5001});
    check("t5_u_stall_held", u_stall, 1);
    stallDir = 0;
    sendUop(4'd0, 5'd16, 32'h5004, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    waitOut(base + 4);

    // random mix against the model
    useFixed = 0; randomMem = 1; randStall = 1;
    base = outCount;
    for (int n = 0; n < 1000; n++) begin
      int kind;
      logic [3:0] ex;
      logic [31:0] addr;
      logic [1:0] size;
      kind = $urandom_range(0, 9);
      ex = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      size = 2'($urandom_range(0, 2));
      addr = {20'h0, 12'($urandom)};
      if ($urandom_range(0, 1) == 1) addr[1:0] = (size == 2'd0) ? addr[1:0] : (size == 2'd1) ? {addr[1], 1'b0} : 2'b00;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      if (kind < 3)
        sendUop(ex, 5'($urandom), $urandom, $urandom, 1'b0, 1'b0, size, 1'($urandom));
      else
        sendUop(ex, 5'($urandom), addr, $urandom, 1'b1, kind >= 7, size, 1'($urandom));
    end
    randStall = 0;
    waitOut(base + 1000);
    repeat (5) @(negedge clk);
    check("end_exp_q_empty", exp_q.size(), 0);
    check("end_req_q_empty", req_q.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
